rf_writeback_ctrl: RTL and testbench

- Write-side controller for the 32x32 register file.
- Merges write requests from two producers onto the register file's single write port (rw / writereg / datawritten):
  - Port A: the single-cycle ALU path.
  - Port B: the long-latency path (load / mul-div), buffered in a small FIFO.
- Exports a pending-write mask so decode can stall on read-after-write hazards.

---
 rtl/rf_writeback_ctrl_pkg.sv | 20 ++
 rtl/rf_writeback_ctrl_if.sv | 33 +++
 rtl/rf_writeback_ctrl_fifo.sv | 74 +++++++
 rtl/rf_writeback_ctrl.sv | 120 ++++++++++++
 tb/tb_rf_writeback_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/rf_writeback_ctrl_pkg.sv
// Shared types and constants for the register-file write-back controller.
package rf_writeback_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wr_req_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[a] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rf_writeback_ctrl_if.sv
// Producer-facing handshakes plus register-file write port and hazard mask.
interface rf_writeback_ctrl_if #(
    parameter int DEPTH = 4
);
    import rf_writeback_ctrl_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  a_valid;
    logic                  a_ready;
    logic [REG_ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0]     a_data;
    logic                  b_valid;
    logic                  b_ready;
    logic [REG_ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0]     b_data;
    logic                  rf_rw;
    logic [REG_ADDR_W-1:0] rf_writereg;
    logic [DATA_W-1:0]     rf_datawritten;
    logic [NUM_REGS-1:0]   pend_mask;
    logic [CNT_W-1:0]      fifo_count;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, rf_rw, rf_writereg, rf_datawritten, pend_mask, fifo_count
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, rf_rw, rf_writereg, rf_datawritten, pend_mask, fifo_count
    );

endinterface

// File: rtl/rf_writeback_ctrl_fifo.sv
// Circular buffer for long-latency write requests; exposes every slot's
// valid bit and address so the hazard mask can see queued destinations.
module wb_fifo
    import rf_writeback_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push_i,
    input  wr_req_t                          push_req_i,
    input  logic                             pop_i,
    output wr_req_t                          head_o,
    output logic                             full_o,
    output logic                             empty_o,
    output logic [$clog2(DEPTH):0]           count_o,
    output logic [DEPTH-1:0]                 ent_valid_o,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wr_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents are qualified by the valid bits, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_req_i;
    end

    // A slot is live when its distance from the read pointer is below occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid_o[i] = ({1'b0, PTR_W'(i) - rd_ptr_q}) < count_q;
            ent_addr_o[i]  = mem_q[i].addr;
        end
    end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Merges the single-cycle ALU writes and buffered long-latency writes onto
// the register file's one write port, with an anti-starvation override for
// the buffered path and a pending-write mask for decode hazard stalls.
module rf_writeback_ctrl
    import rf_writeback_ctrl_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3,
    parameter int DROP_R0      = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    rf_writeback_ctrl_if.slave wb_if
);

    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    wr_req_t                          b_req, head;
    logic                             fifo_full, fifo_empty;
    logic [CNT_W-1:0]                 fifo_count;
    logic [DEPTH-1:0]                 ent_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr;

    logic                  force_b, a_take, a_drop, b_take, b_drop, push, pop;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  rf_rw_q, rf_rw_d;
    logic [REG_ADDR_W-1:0] rf_writereg_q, rf_writereg_d;
    logic [DATA_W-1:0]     rf_data_q, rf_data_d;
    logic [NUM_REGS-1:0]   pend_mask;

    assign b_req.addr = wb_if.b_addr;
    assign b_req.data = wb_if.b_data;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_req_i (b_req),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count),
        .ent_valid_o(ent_valid),
        .ent_addr_o (ent_addr)
    );

    // Arbitration: A wins unless the queued head has waited STARVE_LIMIT cycles.
    // Register-0 requests still consume their slot but never reach the file.
    always_comb begin
        force_b = (starve_q == STARVE_MAX) && !fifo_empty;
        a_take  = wb_if.a_valid && !force_b;
        a_drop  = (DROP_R0 != 0) && (wb_if.a_addr == '0);
        b_take  = wb_if.b_valid && !fifo_full;
        b_drop  = (DROP_R0 != 0) && (wb_if.b_addr == '0);
        push    = b_take && !b_drop;
        pop     = !fifo_empty && (force_b || !wb_if.a_valid);
    end

    // Starvation counter: counts A wins over a waiting head, saturating.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (a_take && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Output-stage selection; address and data hold when nothing is issued.
    always_comb begin
        rf_rw_d       = 1'b0;
        rf_writereg_d = rf_writereg_q;
        rf_data_d     = rf_data_q;
        if (a_take && !a_drop) begin
            rf_rw_d       = 1'b1;
            rf_writereg_d = wb_if.a_addr;
            rf_data_d     = wb_if.a_data;
        end else if (pop) begin
            rf_rw_d       = 1'b1;
            rf_writereg_d = head.addr;
            rf_data_d     = head.data;
        end
    end

    // Output stage and starvation counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q      <= '0;
            rf_rw_q       <= 1'b0;
            rf_writereg_q <= '0;
            rf_data_q     <= '0;
        end else begin
            starve_q      <= starve_d;
            rf_rw_q       <= rf_rw_d;
            rf_writereg_q <= rf_writereg_d;
            rf_data_q     <= rf_data_d;
        end
    end

    // Hazard mask: every queued destination plus the write in flight.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) pend_mask = pend_mask | reg_onehot(ent_addr[i]);
        end
        if (rf_rw_q) pend_mask = pend_mask | reg_onehot(rf_writereg_q);
    end

    assign wb_if.a_ready        = !force_b;
    assign wb_if.b_ready        = !fifo_full;
    assign wb_if.rf_rw          = rf_rw_q;
    assign wb_if.rf_writereg    = rf_writereg_q;
    assign wb_if.rf_datawritten = rf_data_q;
    assign wb_if.pend_mask      = pend_mask;
    assign wb_if.fifo_count     = fifo_count;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_rf_writeback_ctrl;
    import rf_writeback_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_writeback_ctrl_if #(.DEPTH(DEPTH)) bus ();

    rf_writeback_ctrl #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .DROP_R0(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .wb_if(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue is the FIFO, starve counts lost arbitrations.
    wr_req_t     q[$];
    int          starve = 0;
    logic        m_rw   = 1'b0;
    logic [4:0]  m_reg  = '0;
    logic [31:0] m_data = '0;

    always @(posedge clk or negedge rst_n) begin : model
        bit      nonempty, force_b, a_acc, b_acc, pop;
        wr_req_t e;
        if (!rst_n) begin
            q.delete();
            starve = 0;
            m_rw   = 1'b0;
            m_reg  = '0;
            m_data = '0;
        end else begin
            nonempty = (q.size() > 0);
            force_b  = (starve == LIMIT) && nonempty;
            a_acc    = bus.a_valid && !force_b;
            b_acc    = bus.b_valid && (q.size() < DEPTH);
            pop      = nonempty && (force_b || !bus.a_valid);
            if (a_acc && bus.a_addr != 0) begin
                m_rw = 1'b1; m_reg = bus.a_addr; m_data = bus.a_data;
            end else if (pop) begin
                e = q.pop_front();
                m_rw = 1'b1; m_reg = e.addr; m_data = e.data;
            end else begin
                m_rw = 1'b0;
            end
            if (!nonempty || pop) starve = 0;
            else if (a_acc) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
            if (b_acc && bus.b_addr != 0) begin
                e.addr = bus.b_addr;
                e.data = bus.b_data;
                q.push_back(e);
            end
        end
    end

    function automatic logic [31:0] exp_pend();
        logic [31:0] m;
        m = '0;
        foreach (q[i]) m[q[i].addr] = 1'b1;
        if (m_rw) m[m_reg] = 1'b1;
        return m;
    endfunction

    logic a_rdy_s = 1'b1;
    logic b_rdy_s = 1'b1;

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin : compare
        check("a_ready",     {31'd0, bus.a_ready}, (starve == LIMIT && q.size() > 0) ? 32'd0 : 32'd1);
        check("b_ready",     {31'd0, bus.b_ready}, (q.size() != DEPTH) ? 32'd1 : 32'd0);
        check("rf_rw",       {31'd0, bus.rf_rw}, {31'd0, m_rw});
        check("rf_writereg", {27'd0, bus.rf_writereg}, {27'd0, m_reg});
        check("rf_data",     bus.rf_datawritten, m_data);
        check("pend_mask",   bus.pend_mask, exp_pend());
        check("fifo_count",  {29'd0, bus.fifo_count}, q.size());
        a_rdy_s = bus.a_ready;
        b_rdy_s = bus.b_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    endtask

    initial begin
        idle();
        repeat (2) tick();
        rst_n = 1'b1;
        check("reset_rf_rw", {31'd0, bus.rf_rw}, 32'd0);
        check("reset_pend",  bus.pend_mask, 32'd0);
        check("reset_count", {29'd0, bus.fifo_count}, 32'd0);
        check("reset_wreg",  {27'd0, bus.rf_writereg}, 32'd0);

        // Single A write: visible one cycle later, gone the cycle after.
        bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'h1234;
        tick();
        check("a_lat_rw",   {31'd0, bus.rf_rw}, 32'd1);
        check("a_lat_reg",  {27'd0, bus.rf_writereg}, 32'd5);
        check("a_lat_data", bus.rf_datawritten, 32'h1234);
        bus.a_valid = 1'b0;
        tick();
        check("a_done_rw",  {31'd0, bus.rf_rw}, 32'd0);

        // Fill the FIFO with 8..11 while A keeps the port busy, then drain.
        bus.a_valid = 1'b1; bus.a_addr = 5'd20; bus.a_data = 32'hA0;
        bus.b_valid = 1'b1;
        for (int i = 8; i < 12; i++) begin
            bus.b_addr = 5'(i); bus.b_data = 32'hB000 + i;
            tick();
        end
        check("full_count", {29'd0, bus.fifo_count}, 32'd4);
        check("full_bready", {31'd0, bus.b_ready}, 32'd0);
        idle();
        for (int i = 8; i < 12; i++) begin
            tick();
            check("drain_reg",  {27'd0, bus.rf_writereg}, i);
            check("drain_data", bus.rf_datawritten, 32'hB000 + i);
        end
        check("drain_count", {29'd0, bus.fifo_count}, 32'd0);

        // Starvation: addr 12 waits behind three A issues, then is forced.
        bus.a_valid = 1'b1; bus.a_addr = 5'd21; bus.a_data = 32'hC1;
        bus.b_valid = 1'b1; bus.b_addr = 5'd12; bus.b_data = 32'hC12;
        tick();
        bus.b_valid = 1'b0;
        check("starve_a_rdy0", {31'd0, bus.a_ready}, 32'd1);
        tick(); tick(); tick();
        check("starve_a_rdy3", {31'd0, bus.a_ready}, 32'd0);
        check("starve_a_reg",  {27'd0, bus.rf_writereg}, 32'd21);
        tick();
        check("starve_forced", {27'd0, bus.rf_writereg}, 32'd12);
        check("starve_resume", {31'd0, bus.a_ready}, 32'd1);
        tick();
        check("starve_a_again", {27'd0, bus.rf_writereg}, 32'd21);
        idle();
        tick();

        // Push and pop together at count 2.
        bus.a_valid = 1'b1; bus.a_addr = 5'd22; bus.a_data = 32'hD2;
        bus.b_valid = 1'b1; bus.b_addr = 5'd13; bus.b_data = 32'hD13;
        tick();
        bus.b_addr = 5'd14; bus.b_data = 32'hD14;
        tick();
        bus.a_valid = 1'b0;
        bus.b_addr = 5'd15; bus.b_data = 32'hD15;
        tick();
        check("pp_count", {29'd0, bus.fifo_count}, 32'd2);
        check("pp_reg",   {27'd0, bus.rf_writereg}, 32'd13);
        check("pp_pend",  bus.pend_mask, 32'h0000_E000);
        bus.b_valid = 1'b0;
        tick();
        check("pp_pend_14", bus.pend_mask, 32'h0000_C000);
        tick();
        check("pp_pend_15", bus.pend_mask, 32'h0000_8000);
        tick();
        check("pp_pend_0",  bus.pend_mask, 32'h0);

        // Register 0 from both producers.
        bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'hFFFF;
        bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'hEEEE;
        #1;
        check("r0_a_ready", {31'd0, bus.a_ready}, 32'd1);
        check("r0_b_ready", {31'd0, bus.b_ready}, 32'd1);
        tick();
        check("r0_rw",    {31'd0, bus.rf_rw}, 32'd0);
        check("r0_count", {29'd0, bus.fifo_count}, 32'd0);
        check("r0_pend",  bus.pend_mask, 32'h0);
        idle();
        tick();

        // Async reset mid-drain with three entries still queued.
        bus.a_valid = 1'b1; bus.a_addr = 5'd23; bus.a_data = 32'hE3;
        bus.b_valid = 1'b1;
        for (int i = 16; i < 20; i++) begin
            bus.b_addr = 5'(i); bus.b_data = 32'hF000 + i;
            tick();
        end
        idle();
        tick();
        check("pre_rst_count", {29'd0, bus.fifo_count}, 32'd3);
        check("pre_rst_rw",    {31'd0, bus.rf_rw}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_rw",    {31'd0, bus.rf_rw}, 32'd0);
        check("rst_pend",  bus.pend_mask, 32'h0);
        check("rst_count", {29'd0, bus.fifo_count}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_rw", {31'd0, bus.rf_rw}, 32'd0);
        tick();
        check("post_rst_rw2", {31'd0, bus.rf_rw}, 32'd0);

        // Random traffic; requests stay stable while stalled.
        for (int c = 0; c < 3000; c++) begin
            if (!(bus.a_valid && !a_rdy_s)) begin
                bus.a_valid = ($urandom_range(0, 99) < 65);
                bus.a_addr  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bus.a_data  = $urandom;
            end
            if (!(bus.b_valid && !b_rdy_s)) begin
                bus.b_valid = ($urandom_range(0, 99) < 50);
                bus.b_addr  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bus.b_data  = $urandom;
            end
            tick();
        end
        idle();
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
